fp_mul_arbiter: RTL and testbench

//  Shares one single-precision FP multiplier datapath among NUM_REQ requesters.

---
 rtl/fp_mul_pkg.sv | 24 ++
 rtl/fp_mul_arbiter_if.sv | 30 +++
 rtl/fp_rr_arbiter.sv | 30 +++
 rtl/fp_mul_arbiter.sv | 111 +++++++++++
 tb/tb_fp_mul_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared types and constants for the FP multiplier arbiter
package fp_mul_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic rmode_legal(input logic [2:0] rm);
    return rm <= RMM;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - request/response bus between issue logic and the arbiter
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_x;
  logic [NUM_REQ*32-1:0] req_y;
  logic [NUM_REQ*3-1:0]  req_rmode;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_z;
  logic                  rsp_ovrf;
  logic                  rsp_udrf;
  logic                  rsp_inv;

  modport master (
    output req_valid, req_x, req_y, req_rmode, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_inv
  );

  modport slave (
    input  req_valid, req_x, req_y, req_rmode, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_inv
  );

endinterface

// File: rtl/fp_rr_arbiter.sv
// rtl/fp_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module fp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - shares one FP multiplier among NUM_REQ requesters
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_mul_arbiter_if.slave     bus,
  output logic [31:0]         mul_fp_X,
  output logic [31:0]         mul_fp_Y,
  output logic [2:0]          mul_r_mode,
  input  logic [31:0]         mul_fp_Z,
  input  logic                mul_ovrf,
  input  logic                mul_udrf,
  output logic                busy
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  arb_state_e         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] g_vec;
  logic [ID_W-1:0]    g_idx;
  logic               g_any;
  logic [31:0]        g_x;
  logic [31:0]        g_y;
  logic [2:0]         g_rm;

  fp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (g_vec),
    .grant_idx (g_idx),
    .grant_any (g_any)
  );

  assign g_x  = bus.req_x[g_idx*32 +: 32];
  assign g_y  = bus.req_y[g_idx*32 +: 32];
  assign g_rm = bus.req_rmode[g_idx*3 +: 3];

  // Accept only while idle and out of reset so nothing handshakes into a dead op.
  assign bus.req_ready = (state == IDLE && rst_n) ? g_vec : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      mul_fp_X      <= '0;
      mul_fp_Y      <= '0;
      mul_r_mode    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_z     <= '0;
      bus.rsp_ovrf  <= 1'b0;
      bus.rsp_udrf  <= 1'b0;
      bus.rsp_inv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (g_any) begin
            bus.rsp_id <= g_idx;
            rr_ptr     <= ID_W'((int'(g_idx) + 1) % NUM_REQ);
            cnt        <= CNT_W'(MUL_LAT);
            // Illegal modes never reach the multiplier, so its inputs keep the last legal op.
            if (rmode_legal(g_rm)) begin
              mul_fp_X   <= g_x;
              mul_fp_Y   <= g_y;
              mul_r_mode <= g_rm;
              state      <= EXEC;
            end else begin
              bus.rsp_z     <= FP_QNAN;
              bus.rsp_ovrf  <= 1'b0;
              bus.rsp_udrf  <= 1'b0;
              bus.rsp_inv   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bus.rsp_z     <= mul_fp_Z;
            bus.rsp_ovrf  <= mul_ovrf;
            bus.rsp_udrf  <= mul_udrf;
            bus.rsp_inv   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - directed self-checking bench for fp_mul_arbiter
module tb_fp_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mul_fp_X;
  logic [31:0] mul_fp_Y;
  logic [2:0]  mul_r_mode;
  logic [31:0] mul_fp_Z;
  logic        mul_ovrf;
  logic        mul_udrf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] t2_x [4] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40000000};
  logic [31:0] t2_y [4] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] t2_z [4] = '{32'h40800000, 32'h40400000, 32'h3F800000, 32'h40000000};

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  fp_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mul_fp_X   (mul_fp_X),
    .mul_fp_Y   (mul_fp_Y),
    .mul_r_mode (mul_r_mode),
    .mul_fp_Z   (mul_fp_Z),
    .mul_ovrf   (mul_ovrf),
    .mul_udrf   (mul_udrf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external multiplier: only the operand pairs used below.
  function automatic logic [33:0] mul_model(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h40400000, 32'h40400000}: return {32'h41100000, 2'b00};
      {32'h80000000, 32'h3F800000}: return {32'h80000000, 2'b00};
      {32'h40000000, 32'h40000000}: return {32'h40800000, 2'b00};
      {32'h40400000, 32'h3F800000}: return {32'h40400000, 2'b00};
      {32'h3F800000, 32'h3F800000}: return {32'h3F800000, 2'b00};
      {32'h40000000, 32'h3F800000}: return {32'h40000000, 2'b00};
      {32'h7F000000, 32'h7F000000}: return {32'h7F800000, 2'b10};
      {32'h00800000, 32'h00800000}: return {32'h00000000, 2'b01};
      default:                      return '0;
    endcase
  endfunction

  assign {mul_fp_Z, mul_ovrf, mul_udrf} = mul_model(mul_fp_X, mul_fp_Y);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input int id, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] rm, input logic [31:0] ez, input logic eo, input logic eu,
                        input logic ei, input int elat, input int stall);
    int n;
    @(posedge clk); #1;
    bus.req_x[id*32 +: 32]   = x;
    bus.req_y[id*32 +: 32]   = y;
    bus.req_rmode[id*3 +: 3] = rm;
    bus.req_valid[id]        = 1'b1;
    bus.rsp_ready            = (stall == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[id] && n < 20);
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1) << id);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, "_z"}, bus.rsp_z, ez);
    chk({tag, "_flags"}, {29'd0, bus.rsp_ovrf, bus.rsp_udrf, bus.rsp_inv}, {29'd0, eo, eu, ei});
    if (stall > 0) begin
      @(posedge clk); #1;
      bus.req_valid = '1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_stall_z"}, bus.rsp_z, ez);
        chk({tag, "_stall_ready"}, 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, {30'd0, busy, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ng, cyc, last_cyc, rsp_cyc, gid, last_g;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_rmode = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with a request pending that must not be accepted.
    bus.req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy_valid", {30'd0, busy, bus.rsp_valid}, 32'd0);
    chk("rst_mul", mul_fp_X | mul_fp_Y | 32'(mul_r_mode), 32'd0);
    chk("rst_rsp", bus.rsp_z | 32'(bus.rsp_id) | {29'd0, bus.rsp_ovrf, bus.rsp_udrf, bus.rsp_inv}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Basic op and flag passthrough on requester 0.
    run_op("t1", 0, 32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 1'b0, 1'b0, 1'b0, MUL_LAT + 1, 0);
    run_op("t1_ovf", 0, 32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 1'b1, 1'b0, 1'b0, MUL_LAT + 1, 0);
    run_op("t1_udf", 0, 32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 1'b0, 1'b1, 1'b0, MUL_LAT + 1, 0);

    // Fresh round-robin pointer, then all requesters held valid.
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_x[i*32 +: 32]   = t2_x[i];
      bus.req_y[i*32 +: 32]   = t2_y[i];
      bus.req_rmode[i*3 +: 3] = 3'd0;
    end
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    ng = 0; cyc = 0; last_cyc = 0; rsp_cyc = 0; last_g = -1;
    while (ng < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid && last_g >= 0) begin
        chk("t2_rsp_id", 32'(bus.rsp_id), 32'(last_g));
        chk("t2_rsp_z", bus.rsp_z, t2_z[last_g]);
        rsp_cyc = cyc;
      end
      if (|bus.req_ready) begin
        gid = 0;
        for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) gid = k;
        chk("t2_onehot", 32'($countones(bus.req_ready)), 32'd1);
        chk("t2_order", 32'(gid), 32'(ng % NUM_REQ));
        if (ng > 0) begin
          chk("t2_spacing", 32'(cyc - last_cyc), 32'(MUL_LAT + 2));
          chk("t2_after_hs", 32'(cyc - rsp_cyc), 32'd1);
        end
        last_cyc = cyc;
        last_g   = gid;
        ng++;
      end
    end
    chk("t2_grants", 32'(ng), 32'd5);
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 20);
    chk("t2_last_id", 32'(bus.rsp_id), 32'd0);
    chk("t2_last_z", bus.rsp_z, 32'h40800000);
    @(posedge clk);

    // Illegal rounding mode bypasses the multiplier.
    run_op("t3", 2, 32'h3F800000, 32'h3F800000, 3'b101, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1, 0);
    chk("t3_mul_x", mul_fp_X, 32'h40000000);
    chk("t3_mul_y", mul_fp_Y, 32'h40000000);
    chk("t3_mul_rm", 32'(mul_r_mode), 32'd0);

    // Negative zero result, then a long consumer stall.
    run_op("t4", 1, 32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, MUL_LAT + 1, 10);

    // Reset while executing drops the op.
    @(posedge clk); #1;
    bus.req_x[32 +: 32]  = 32'h40400000;
    bus.req_y[32 +: 32]  = 32'h40400000;
    bus.req_rmode[3 +: 3] = 3'd0;
    bus.req_valid[1]     = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[1] && n < 20);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("t5_exec_busy", 32'(busy), 32'd1);
    chk("t5_exec_mul_x", mul_fp_X, 32'h40400000);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy_valid", {30'd0, busy, bus.rsp_valid}, 32'd0);
    chk("t5_rst_mul", mul_fp_X | mul_fp_Y | 32'(mul_r_mode), 32'd0);
    chk("t5_rst_rsp", bus.rsp_z | 32'(bus.rsp_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) n++;
    end
    chk("t5_no_rsp", 32'(n), 32'd0);
    run_op("t5_req3", 3, 32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 1'b0, 1'b0, 1'b0, MUL_LAT + 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
